mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
- Initiator side of the word-wide RAM bus (en / write_en / write_sel / addr / data).
- Accepts one load or store request at a time from the pipeline memory stage over a valid/ready handshake.
- Converts each request to a word-aligned bus transaction with byte-lane selects.
- Holds the bus stable for a programmable latency, then returns aligned, sign- or zero-extended load data with a one-cycle response strobe.

Parameters:
- ADDR_W, 32, address width; matches `ADDR_BUS`.
- DATA_W, 32, data width; matches `DATA_BUS`. Fixed at 32; any other value is unsupported.
- BUS_LAT, 1, cycles the bus is held before read data is sampled or a write is considered committed. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  extended load data; 0 for stores
- rsp_err  out  1  request rejected (reserved size, or misaligned when the optional feature is on)
- bus_en  out  1  RAM enable
- bus_write_en  out  1  RAM write enable
- bus_write_sel  out  4  byte-lane write selects
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0
- bus_wdata  out  DATA_W  lane-positioned store data
- bus_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous): every output is driven to 0.
  - State goes to IDLE and the latency counter to 0.
  - req_ready is 0 while rst is high and 1 in IDLE afterwards.
- Lane mapping: byte offset k = req_addr[1:0] maps to lane k, i.e. data[8k+7:8k] and write_sel[k].
  - Byte: sel = 1<<k.
  - Half: sel = 0011 for k = 0, 1100 for k = 2.
  - Word: sel = 1111.
  - bus_wdata = req_wdata shifted left by 8k (truncated to 32 bits). Lanes that are not selected carry the shifted value and are ignored by the RAM.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write, size, signed, offset, sel and wdata. Set bus_addr = {req_addr[ADDR_W-1:2], 2'b00}.
  - Reserved size (3) goes to RESP with rsp_err = 1. No bus activity occurs.
  - Any other size goes to BUS.
- BUS:
  - bus_en = 1 and bus_write_en = latched write.
  - bus_write_sel = latched sel for stores, 0 for loads.
  - Addr and wdata are held constant.
  - The counter counts 0..BUS_LAT-1. In the final count cycle, load data is sampled from bus_rdata into an internal register; then go to RESP.
  - The bus is therefore asserted for exactly BUS_LAT cycles.
- RESP:
  - All bus outputs return to 0.
  - rsp_valid = 1 for exactly one cycle.
  - Load: shift the sampled word right by 8k, mask to size, extend per req_signed.
    - Signed byte 0x80 gives 0xFFFFFF80; unsigned gives 0x00000080.
  - Store: rsp_rdata = 0.
  - Next state is IDLE.
- req_ready is 0 outside IDLE. Back-to-back requests therefore see BUS_LAT + 2 cycles per request, from accept to the next possible accept.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid is the only qualifier.
- Input changes while the master is not ready are ignored. The requester must hold req_* until accepted.
- Reset asserted mid-transaction: the transaction is abandoned, bus_en drops immediately, and no response is generated.

Optional Feature:
- MEM_MISALIGN_CHECK_EN:
  - Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, goes IDLE → RESP with rsp_err = 1. No bus cycle is issued.
  - Undefined: the misaligned low address bits are forced to the natural alignment before the lane computation (half clears bit 0, word clears bits [1:0]), and the access proceeds normally with rsp_err = 0.

Decomposition:
- Shared package/header (alongside bus.v):
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - state encodings ST_IDLE, ST_BUS, ST_RESP.
  - lane-select constants.
- One sub-module, mem_lane_align: purely combinational.
  - Computes sel and shifted wdata from size and offset.
  - Performs load extraction and extension from word, offset, size and signed.
  - Can be reused by the simulation bench's reference model.
- The FSM and counter live in mem_bus_master.

Test Plan:
- Word store: addr 0x10, data 0xDEADBEEF, BUS_LAT 1.
  - Required: bus_en = 1 and write_en = 1 for 1 cycle, sel = 1111, bus_addr = 0x10. rsp_valid two cycles after accept, rsp_rdata = 0.
- Byte store: addr 0x13, data 0x000000AB.
  - Required: sel = 1000, bus_wdata[31:24] = 0xAB, bus_addr = 0x10.
- Signed byte load: addr 0x11, bus_rdata = 0x12348056.
  - Required: rsp_rdata = 0xFFFFFF80.
  - Same access unsigned: 0x00000080.
- Unsigned half load: addr 0x12, bus_rdata = 0xBEEF0000.
  - Required: rsp_rdata = 0x0000BEEF.
  - With BUS_LAT = 3: bus_en is high for exactly 3 cycles.
- Reserved size 3: rsp_err = 1, bus_en never asserted.
  - Word at 0x11 with MEM_MISALIGN_CHECK_EN defined: rsp_err = 1, no bus cycle.
  - Same access without the macro: bus_addr = 0x10, sel = 1111, rsp_err = 0.
- Assert rst during the BUS state of a 3-cycle load.
  - Required: bus_en falls in the same cycle, no rsp_valid, req_ready = 1 after rst is released.

Source files
------------

// File: rtl/mem_bus_master_pkg.sv
// Shared encodings for the word-wide RAM bus master.
// Contents: access size codes, FSM state type, and byte-lane select constants.
package mem_bus_master_pkg;

   // Access size encodings as carried on req_size
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   // Master FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Byte-lane select patterns before positioning by the byte offset
   localparam logic [3:0] SEL_NONE = 4'b0000;
   localparam logic [3:0] SEL_BYTE = 4'b0001;
   localparam logic [3:0] SEL_HALF = 4'b0011;
   localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the RAM bus.
// Store side: size/offset -> lane selects and lane-positioned write data.
// Load side : word/offset/size/signed -> right-justified, extended load data.
// Ports:
//   size_i      access size code
//   offset_i    byte offset within the word (already alignment-adjusted)
//   signed_i    sign-extend load result
//   wdata_i     right-justified store data
//   rword_i     raw word read from the RAM
//   sel_o       byte-lane selects
//   wdata_sh_o  store data shifted to its lanes
//   rdata_ext_o extracted and extended load data
module mem_lane_align
   import mem_bus_master_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_sh_o,
   output logic [31:0] rdata_ext_o
);

   logic [4:0]  shamt_s;
   logic [31:0] rword_sh_s;

   // Lane positioning for stores and extraction/extension for loads
   always_comb begin
      shamt_s    = {offset_i, 3'b000};
      wdata_sh_o = wdata_i << shamt_s;
      rword_sh_s = rword_i >> shamt_s;
      case (size_i)
         SIZE_BYTE: begin
            sel_o       = SEL_BYTE << offset_i;
            rdata_ext_o = signed_i ? {{24{rword_sh_s[7]}}, rword_sh_s[7:0]}
                                   : {24'h000000, rword_sh_s[7:0]};
         end
         SIZE_HALF: begin
            sel_o       = SEL_HALF << {offset_i[1], 1'b0};
            rdata_ext_o = signed_i ? {{16{rword_sh_s[15]}}, rword_sh_s[15:0]}
                                   : {16'h0000, rword_sh_s[15:0]};
         end
         SIZE_WORD: begin
            sel_o       = SEL_WORD;
            rdata_ext_o = rword_sh_s;
         end
         default: begin
            sel_o       = SEL_NONE;
            rdata_ext_o = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_master.sv
// Initiator side of the word-wide RAM bus. Accepts one load/store at a time
// over valid/ready, drives a word-aligned bus cycle for BUS_LAT clocks, then
// returns extended load data with a one-cycle rsp_valid strobe.
// Optional build macro: MEM_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses are rejected with rsp_err; otherwise the low address bits
// are forced to natural alignment and the access proceeds.
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              request handshake
//   req_write/size/signed/addr/wdata request fields
//   rsp_valid/rsp_rdata/rsp_err      response (rdata/err hold until next rsp)
//   bus_en/write_en/write_sel/addr/wdata, bus_rdata   RAM bus
module mem_bus_master
   import mem_bus_master_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BUS_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_en,
   output logic              bus_write_en,
   output logic [3:0]        bus_write_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam logic [3:0] LAT_LAST = 4'(BUS_LAT - 1);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q, signed_q;
   logic [1:0]        size_q, off_q;
   logic              req_ready_q, rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              bus_en_q, bus_write_en_q;
   logic [3:0]        bus_write_sel_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [DATA_W-1:0] bus_wdata_q;

   logic              misalign_s;
   logic [1:0]        off_s;
   logic [1:0]        al_size_s, al_off_s;
   logic              al_signed_s;
   logic [3:0]        sel_s;
   logic [31:0]       wdata_sh_s, rdata_ext_s;

   // Effective byte offset of the incoming request and misalignment detection
   always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
      off_s      = req_addr[1:0];
      misalign_s = ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
      if (req_size == SIZE_HALF) begin
         off_s = {req_addr[1], 1'b0};
      end else if (req_size == SIZE_WORD) begin
         off_s = 2'b00;
      end else begin
         off_s = req_addr[1:0];
      end
`endif
   end

   // One aligner serves both phases: the live request in IDLE (store lanes),
   // the latched request in BUS (load extraction of bus_rdata).
   always_comb begin
      if (state_q == ST_IDLE) begin
         al_size_s   = req_size;
         al_off_s    = off_s;
         al_signed_s = req_signed;
      end else begin
         al_size_s   = size_q;
         al_off_s    = off_q;
         al_signed_s = signed_q;
      end
   end

   mem_lane_align u_align (
      .size_i      (al_size_s),
      .offset_i    (al_off_s),
      .signed_i    (al_signed_s),
      .wdata_i     (req_wdata),
      .rword_i     (bus_rdata),
      .sel_o       (sel_s),
      .wdata_sh_o  (wdata_sh_s),
      .rdata_ext_o (rdata_ext_s)
   );

   // Master FSM, latency counter and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= 4'd0;
         wr_q            <= 1'b0;
         signed_q        <= 1'b0;
         size_q          <= 2'd0;
         off_q           <= 2'd0;
         req_ready_q     <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_err_q       <= 1'b0;
         rsp_rdata_q     <= '0;
         bus_en_q        <= 1'b0;
         bus_write_en_q  <= 1'b0;
         bus_write_sel_q <= 4'b0000;
         bus_addr_q      <= '0;
         bus_wdata_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rsp_valid_q <= 1'b0;
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  wr_q        <= req_write;
                  size_q      <= req_size;
                  signed_q    <= req_signed;
                  off_q       <= off_s;
                  cnt_q       <= 4'd0;
                  if ((req_size == SIZE_RSVD) || misalign_s) begin
                     // Rejected: answer directly without touching the bus
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q         <= ST_BUS;
                     bus_en_q        <= 1'b1;
                     bus_write_en_q  <= req_write;
                     bus_write_sel_q <= req_write ? sel_s : SEL_NONE;
                     bus_addr_q      <= {req_addr[ADDR_W-1:2], 2'b00};
                     bus_wdata_q     <= wdata_sh_s;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_BUS: begin
               if (cnt_q == LAT_LAST) begin
                  // Final bus cycle: capture read data already extended
                  cnt_q           <= 4'd0;
                  state_q         <= ST_RESP;
                  bus_en_q        <= 1'b0;
                  bus_write_en_q  <= 1'b0;
                  bus_write_sel_q <= 4'b0000;
                  bus_addr_q      <= '0;
                  bus_wdata_q     <= '0;
                  rsp_valid_q     <= 1'b1;
                  rsp_err_q       <= 1'b0;
                  rsp_rdata_q     <= wr_q ? 32'h0000_0000 : rdata_ext_s;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_RESP: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_IDLE;
               rsp_valid_q <= 1'b0;
               bus_en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign bus_en        = bus_en_q;
   assign bus_write_en  = bus_write_en_q;
   assign bus_write_sel = bus_write_sel_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;

endmodule
